// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : uart_tx_arbiter
// Description: Two-source byte FIFOs sharing one uart_tx, with a round-robin
//              or strict-priority grant FSM. Optional drop counters are
//              enabled by UART_ARB_DROPCNT_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    input  logic [7:0]  s0_data,
    input  logic        s1_valid,
    input  logic [7:0]  s1_data,
    input  logic        prio_s1,
    input  logic        ovf_clr,
    input  logic        tx_rdy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        s0_full,
    output logic        s1_full,
    output logic        s0_ovf,
    output logic        s1_ovf,
`ifdef UART_ARB_DROPCNT_EN
    output logic [7:0]  s0_drop_cnt,
    output logic [7:0]  s1_drop_cnt,
`endif
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_last_s1;
    logic [1:0]       w_valid;
    logic [1:0]       w_full;
    logic [1:0]       w_empty;
    logic [1:0]       w_ovf;
    logic [1:0]       w_pop;
    logic [1:0][7:0]  w_head;
    logic             w_any;
    logic             w_pick_s1;
    logic             w_go;
`ifdef UART_ARB_DROPCNT_EN
    logic [1:0][7:0]  w_drop_cnt;
`endif

    assign w_valid = {s1_valid, s0_valid};

    for (genvar g = 0; g < 2; g++) begin : g_src
        logic [AW:0] r_wptr;
        logic [AW:0] r_rptr;
        logic [7:0]  r_mem [DEPTH];
        logic        r_ovf;
        logic [7:0]  w_din;
        logic        w_push;
        logic        w_drop;

        assign w_din      = (g == 0) ? s0_data : s1_data;
        assign w_full[g]  = (r_wptr[AW] != r_rptr[AW]) &&
                            (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        assign w_empty[g] = (r_wptr == r_rptr);
        // Fullness is taken from the registered pointers, so a same-cycle
        // pop never makes room for this cycle's write.
        assign w_push     = w_valid[g] & ~w_full[g];
        assign w_drop     = w_valid[g] &  w_full[g];
        assign w_head[g]  = r_mem[r_rptr[AW-1:0]];
        assign w_ovf[g]   = r_ovf;

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= w_din;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop[g]) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end else if (ovf_clr) begin
                    r_ovf <= 1'b0;
                end
            end
        end

`ifdef UART_ARB_DROPCNT_EN
        logic [7:0] r_drop_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_drop_cnt <= '0;
            end else if (ovf_clr) begin
                r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
            end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end

        assign w_drop_cnt[g] = r_drop_cnt;
`endif
    end

    assign s0_full = w_full[0];
    assign s1_full = w_full[1];
    assign s0_ovf  = w_ovf[0];
    assign s1_ovf  = w_ovf[1];
`ifdef UART_ARB_DROPCNT_EN
    assign s0_drop_cnt = w_drop_cnt[0];
    assign s1_drop_cnt = w_drop_cnt[1];
`endif

    // Source 1 wins if it alone has data, if it has priority, or if source 0
    // was granted last; r_last_s1 resets to 1 so source 0 is favoured first.
    assign w_any     = ~(&w_empty);
    assign w_pick_s1 = ~w_empty[1] & (w_empty[0] | prio_s1 | ~r_last_s1);
    assign w_go      = (r_state == ST_IDLE) & tx_rdy & w_any;
    assign w_pop     = {w_go & w_pick_s1, w_go & ~w_pick_s1};
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last_s1 <= 1'b1;
            tx_en     <= 1'b0;
            tx_data   <= 8'h00;
            grant     <= 2'b00;
        end else begin
            tx_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        tx_data   <= w_pick_s1 ? w_head[1] : w_head[0];
                        grant     <= w_pick_s1 ? 2'b10 : 2'b01;
                        r_last_s1 <= w_pick_s1;
                        tx_en     <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_HOLD;
                // The transmitter drops tx_rdy one cycle late; skip that cycle.
                ST_HOLD:  r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (tx_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
